// File: rtl/polyfilt_pkg.sv
// Shared definitions for the polyphase interpolate/decimate-by-2 filters:
// prototype coefficients, default widths and the phase FSM encoding.
package polyfilt_pkg;

  localparam int IN_W  = 8;
  localparam int ACC_W = 17;
  localparam int OUT_W = 9;

  // Prototype taps; even branch uses {H0, H2}, odd branch uses {H1, H3}
  localparam int H0 = 124;
  localparam int H1 = 214;
  localparam int H2 = 57;
  localparam int H3 = -33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2
  } state_t;

  typedef enum logic {
    BR_E = 1'b0,
    BR_O = 1'b1
  } branch_t;

endpackage

// File: rtl/polyinterp_if.sv
// Sample stream bundle: input sample handshake plus registered output stream.
// valid/ready: a sample moves on a rising edge where in_valid && in_ready; the
// source holds x_in stable until then. out_valid has no ready and must be taken.
interface polyinterp_if
  import polyfilt_pkg::*;
#(
  parameter int P_IN_W  = IN_W,
  parameter int P_OUT_W = OUT_W
) ();

  logic signed [P_IN_W-1:0]  x_in;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [P_OUT_W-1:0] y_out;
  logic                      out_valid;

  modport master (
    output x_in,
    output in_valid,
    input  in_ready,
    input  y_out,
    input  out_valid
  );

  modport slave (
    input  x_in,
    input  in_valid,
    output in_ready,
    output y_out,
    output out_valid
  );

endinterface

// File: rtl/poly_branch.sv
// Combinational shift-add for one polyphase branch: a*x_cur + b*x_prev,
// with (a, b) = (124, 57) for the even branch and (214, -33) for the odd one.
module poly_branch
  import polyfilt_pkg::*;
#(
  parameter branch_t BRANCH  = BR_E,
  parameter int      P_IN_W  = IN_W,
  parameter int      P_ACC_W = ACC_W
) (
  input  logic signed [P_IN_W-1:0]  i_x_cur,
  input  logic signed [P_IN_W-1:0]  i_x_prev,
  output logic signed [P_ACC_W-1:0] o_acc
);

  logic signed [P_ACC_W-1:0] w_xc;
  logic signed [P_ACC_W-1:0] w_xp;

  assign w_xc = P_ACC_W'(i_x_cur);
  assign w_xp = P_ACC_W'(i_x_prev);

  generate
    if (BRANCH == BR_E) begin : g_even
      // 124 = 128 - 4, 57 = 64 - 8 + 1
      assign o_acc = (w_xc <<< 7) - (w_xc <<< 2)
                   + (w_xp <<< 6) - (w_xp <<< 3) + w_xp;
    end else begin : g_odd
      // 214 = 256 - 32 - 8 - 2, 33 = 32 + 1
      assign o_acc = (w_xc <<< 8) - (w_xc <<< 5) - (w_xc <<< 3) - (w_xc <<< 1)
                   - (w_xp <<< 5) - w_xp;
    end
  endgenerate

endmodule

// File: rtl/polyinterp.sv
// Two-phase polyphase interpolate-by-2 FIR: one input sample yields an even
// then an odd output on consecutive cycles.
module polyinterp
  import polyfilt_pkg::*;
#(
  parameter int P_IN_W  = IN_W,
  parameter int P_ACC_W = ACC_W,
  parameter int P_OUT_W = OUT_W
) (
  input  logic         clk,
  input  logic         reset,
  polyinterp_if.slave  bus,
  output state_t       o_state
);

  state_t                    r_state;
  state_t                    w_next;
  logic signed [P_IN_W-1:0]  r_x_cur;
  logic signed [P_IN_W-1:0]  r_x_prev;
  logic signed [P_OUT_W-1:0] r_y;
  logic signed [P_OUT_W-1:0] w_y_next;
  logic                      r_out_valid;
  logic                      w_out_valid_next;
  logic                      w_accept;
  logic signed [P_ACC_W-1:0] w_acc_e;
  logic signed [P_ACC_W-1:0] w_acc_o;
  logic signed [P_OUT_W-1:0] w_y_e;
  logic signed [P_OUT_W-1:0] w_y_o;

  poly_branch #(.BRANCH(BR_E), .P_IN_W(P_IN_W), .P_ACC_W(P_ACC_W)) u_even (
    .i_x_cur (r_x_cur),
    .i_x_prev(r_x_prev),
    .o_acc   (w_acc_e)
  );

  poly_branch #(.BRANCH(BR_O), .P_IN_W(P_IN_W), .P_ACC_W(P_ACC_W)) u_odd (
    .i_x_cur (r_x_cur),
    .i_x_prev(r_x_prev),
    .o_acc   (w_acc_o)
  );

  // Floor scaling: keep the top OUT_W accumulator bits
  assign w_y_e = P_OUT_W'(w_acc_e >>> (P_ACC_W - P_OUT_W));
  assign w_y_o = P_OUT_W'(w_acc_o >>> (P_ACC_W - P_OUT_W));

  assign bus.in_ready  = (r_state != PH0);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.y_out     = r_y;
  assign bus.out_valid = r_out_valid;
  assign o_state       = r_state;

  always_comb begin
    w_next           = r_state;
    w_y_next         = r_y;
    w_out_valid_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = PH0;
      end
      PH0: begin
        w_y_next         = w_y_e;
        w_out_valid_next = 1'b1;
        w_next           = PH1;
      end
      PH1: begin
        // Odd output uses the history before this edge's accept lands
        w_y_next         = w_y_o;
        w_out_valid_next = 1'b1;
        w_next           = w_accept ? PH0 : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_x_cur     <= '0;
      r_x_prev    <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_y         <= w_y_next;
      r_out_valid <= w_out_valid_next;
      if (w_accept) begin
        r_x_prev <= r_x_cur;
        r_x_cur  <= bus.x_in;
      end
    end
  end

endmodule

// File: tb/tb_polyinterp.sv
// Directed bench for polyinterp: expected outputs are hand-computed and queued,
// a monitor pops one per out_valid, directed steps check handshake and state.
module tb_polyinterp;
  import polyfilt_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     checks;
  int     errors;
  logic [OUT_W-1:0] exp_q[$];

  polyinterp_if bus ();

  polyinterp dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .o_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int v);
    logic [31:0] t;
    t = v;
    exp_q.push_back(t[OUT_W-1:0]);
  endtask

  // Offer x until accepted (bounded), then drop in_valid
  task automatic send(input int x);
    logic [31:0] t;
    logic        acc;
    bit          done;
    t = x;
    bus.x_in     = t[IN_W-1:0];
    bus.in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      acc = bus.in_ready;
      tick();
      if (acc) done = 1'b1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed no accept expected accept of %0d", x);
    end
  endtask

  // scoreboard monitor, sampled on the opposite edge
  always @(negedge clk) begin
    if (reset && bus.out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_out: observed y_out %0d expected no sample", $signed(bus.y_out));
      end else begin
        logic [OUT_W-1:0] e;
        e = exp_q.pop_front();
        assert (bus.y_out === e) else begin
          errors++;
          $error("FAIL y_out: observed %0d expected %0d", $signed(bus.y_out), $signed(e));
        end
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_in     = '0;

    // reset state
    repeat (3) tick();
    chk("rst_y_out", 32'(bus.y_out), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    reset = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // impulse 64 then zeros at max rate
    push(31); push(53); send(64);
    chk("imp_state_ph0", 32'(dbg_state), 32'(PH0));
    chk("imp_ready_ph0", 32'(bus.in_ready), 0);
    push(14); push(-9); send(0);
    chk("imp_ov_stream", 32'(bus.out_valid), 1);
    push(0); push(0); send(0);
    repeat (2) tick();
    chk("imp_state_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    chk("imp_ov_idle", 32'(bus.out_valid), 0);

    // stall: in_valid held through PH0, x=40 from zero history
    bus.x_in = 8'sd40;
    bus.in_valid = 1'b1;
    push(19); push(33); push(28); push(28);
    chk("stall_rdy0", 32'(bus.in_ready), 1);
    tick();
    chk("stall_rdy1", 32'(bus.in_ready), 0);
    tick();
    chk("stall_rdy2", 32'(bus.in_ready), 1);
    tick();
    chk("stall_rdy3", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    repeat (2) tick();
    chk("gap_state", 32'(dbg_state), 32'(IDLE));
    // 3-cycle gap: out_valid low, history kept
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_ov", 32'(bus.out_valid), 0);
    end
    push(-11); push(-39); send(-40);

    // DC 100
    push(39); push(88); send(100);
    for (int i = 0; i < 7; i++) begin
      push(70); push(70); send(100);
      chk("dc_ov", 32'(bus.out_valid), 1);
    end

    // negative full scale
    push(-40); push(-120); send(-128);
    for (int i = 0; i < 3; i++) begin
      push(-91); push(-91); send(-128);
    end
    repeat (4) tick();
    chk("nfs_idle", 32'(dbg_state), 32'(IDLE));

    // mid-operation reset during PH0
    send(64);
    chk("mid_state_ph0", 32'(dbg_state), 32'(PH0));
    reset = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(bus.out_valid), 0);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_rst_y", 32'(bus.y_out), 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("mid_post_ov", 32'(bus.out_valid), 0);
    push(31); push(53); send(64);
    repeat (4) tick();

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
